// File: rtl/fsm_dispatch.sv
// Top-level instruction sequencer: fetch, latch, one-hot decode, then launch the
// class sub-FSM and wait for its completion under a watchdog.
module fsm_dispatch #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ins,
    input  logic [3:0]  done,
    output logic        mem_read,
    output logic        load_ins,
    output logic [31:0] code,
    output logic [3:0]  start,
    output logic        busy,
    output logic        illegal,
    output logic        timeout,
    output logic [63:0] instret
);

    localparam int unsigned WdW = $clog2(TIMEOUT) + 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFetch    = 3'd1,
        StLatch    = 3'd2,
        StDecode   = 3'd3,
        StDispatch = 3'd4,
        StWait     = 3'd5,
        StTrap     = 3'd6
    } state_e;

    state_e         state_q;
    logic [1:0]     cls_q;
    logic [WdW-1:0] wdog_q;
    logic [31:0]    code_q;
    logic           illegal_q;
    logic           timeout_q;
    logic [63:0]    instret_q;

    logic [1:0] dec_cls;
    logic       dec_legal;
    logic       unused_ins;

    assign unused_ins = ^ins[31:7];

    // Class index matches the bit order of start/done: ALU, MEM, BRJ, UPP.
    always_comb begin
        dec_cls   = 2'd0;
        dec_legal = (ins[1:0] == 2'b11);
        case (ins[6:2])
            5'd4, 5'd12:         dec_cls = 2'd0;
            5'd0, 5'd8:          dec_cls = 2'd1;
            5'd24, 5'd25, 5'd27: dec_cls = 2'd2;
            5'd5, 5'd13:         dec_cls = 2'd3;
            default:             dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cls_q     <= 2'd0;
            wdog_q    <= '0;
            code_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (run) state_q <= StFetch;
                end
                StFetch: begin
                    if (mem_ready) state_q <= StLatch;
                end
                StLatch: state_q <= StDecode;
                StDecode: begin
                    code_q <= 32'd1 << ins[6:2];
                    cls_q  <= dec_cls;
                    if (dec_legal) begin
                        state_q <= StDispatch;
                    end else begin
                        state_q   <= StTrap;
                        illegal_q <= 1'b1;
                    end
                end
                StDispatch: begin
                    wdog_q  <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // Completion takes priority over the watchdog limit.
                    if (done[cls_q]) begin
                        instret_q <= instret_q + 64'd1;
                        state_q   <= run ? StFetch : StIdle;
                    end else if (wdog_q == WdLast) begin
                        state_q   <= StTrap;
                        timeout_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                StTrap: state_q <= StTrap;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_read = (state_q == StFetch);
        load_ins = (state_q == StLatch);
        start    = (state_q == StDispatch) ? (4'b0001 << cls_q) : 4'b0000;
        busy     = (state_q == StFetch) || (state_q == StLatch) || (state_q == StDecode) ||
                   (state_q == StDispatch) || (state_q == StWait);
    end

    assign code    = code_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_fsm_dispatch.sv
// Directed bench for fsm_dispatch: fetch/decode/dispatch timing, stalls, traps,
// watchdog limit, run deassertion and mid-instruction reset.
module tb_fsm_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        mem_ready;
    logic [31:0] ins;
    logic [3:0]  done;
    logic        mem_read;
    logic        load_ins;
    logic [31:0] code;
    logic [3:0]  start;
    logic        busy;
    logic        illegal;
    logic        timeout;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;
    int cnt;

    fsm_dispatch #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_ready (mem_ready),
        .ins       (ins),
        .done      (done),
        .mem_read  (mem_read),
        .load_ins  (load_ins),
        .code      (code),
        .start     (start),
        .busy      (busy),
        .illegal   (illegal),
        .timeout   (timeout),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; mem_ready = 1'b1; ins = 32'h0; done = 4'h0;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_code", 64'(code), 64'd0);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_load_ins", 64'(load_ins), 64'd0);
        chk("rst_flags", {62'd0, illegal, timeout}, 64'd0);
        chk("rst_instret", instret, 64'd0);

        // add: c0 IDLE with run high
        ins = 32'h0020_8033; run = 1'b1;
        step();
        chk("add_c1_fetch", {62'd0, mem_read, busy}, 64'd3);
        step();
        chk("add_c2_latch", {62'd0, load_ins, mem_read}, 64'd2);
        step();
        chk("add_c3_decode", {59'd0, load_ins, start}, 64'd0);
        step();
        chk("add_c4_start", 64'(start), 64'h1);
        chk("add_c4_code", 64'(code), 64'h1000);
        step();
        chk("add_c5_start_off", 64'(start), 64'd0);
        step();
        step();
        chk("add_c7_instret", instret, 64'd0);
        done = 4'b0001;
        step();
        done = 4'b0000;
        chk("add_c8_fetch", 64'(mem_read), 64'd1);
        chk("add_c8_instret", instret, 64'd1);

        // ld with five stalled fetch cycles
        ins = 32'h0000_0003; mem_ready = 1'b0; cnt = 0;
        repeat (5) begin
            if (mem_read) cnt++;
            step();
        end
        mem_ready = 1'b1;
        if (mem_read) cnt++;
        step();
        chk("ld_fetch_cycles", 64'(cnt), 64'd6);
        chk("ld_latch", 64'(load_ins), 64'd1);
        step();
        step();
        chk("ld_start", 64'(start), 64'h2);
        chk("ld_code", 64'(code), 64'h1);
        step();
        done = 4'b1101;  // other classes' done must be ignored
        step();
        chk("ld_other_done_ignored", {63'd0, busy}, 64'd1);
        chk("ld_other_done_instret", instret, 64'd1);
        run = 1'b0; done = 4'b0010;
        step();
        done = 4'b0000;
        chk("ld_idle_busy", 64'(busy), 64'd0);
        chk("ld_instret", instret, 64'd2);
        step();
        step();
        chk("ld_no_fetch", 64'(mem_read), 64'd0);

        // illegal opcode 31
        ins = 32'h0000_007F; run = 1'b1;
        step();
        chk("ill_rerun_fetch", 64'(mem_read), 64'd1);
        step();
        step();
        step();
        chk("ill_flag", 64'(illegal), 64'd1);
        chk("ill_busy", 64'(busy), 64'd0);
        chk("ill_code", 64'(code), 64'h8000_0000);
        cnt = 0;
        done = 4'b1111;
        repeat (6) begin
            if (start != 4'b0000 || mem_read || busy) cnt++;
            step();
        end
        done = 4'b0000;
        chk("ill_held", 64'(cnt), 64'd0);
        chk("ill_timeout_clear", 64'(timeout), 64'd0);

        // watchdog expiry, beq (BRJ)
        do_reset();
        chk("wd_reset_illegal", 64'(illegal), 64'd0);
        ins = 32'h0000_0063;
        step(); step(); step(); step();
        chk("wd_start", 64'(start), 64'h4);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!busy) break;
            cnt++;
        end
        chk("wd_wait_cycles", 64'(cnt), 64'd8);
        chk("wd_timeout", 64'(timeout), 64'd1);
        chk("wd_illegal", 64'(illegal), 64'd0);

        // done arrives in 8th WAIT cycle, lui (UPP)
        do_reset();
        ins = 32'h0000_0037;
        step(); step(); step(); step();
        chk("lim_start", 64'(start), 64'h8);
        step();
        repeat (7) step();
        done = 4'b1000;
        step();
        done = 4'b0000;
        chk("lim_fetch", 64'(mem_read), 64'd1);
        chk("lim_timeout", 64'(timeout), 64'd0);
        chk("lim_instret", instret, 64'd1);

        // build instret to 5 with ALU instructions, then reset during WAIT
        ins = 32'h0020_8033;
        repeat (4) begin
            step(); step(); step(); step();
            done = 4'b0001;
            step();
            done = 4'b0000;
        end
        chk("rw_instret5", instret, 64'd5);
        chk("rw_fetch", 64'(mem_read), 64'd1);
        step(); step(); step(); step();
        chk("rw_in_wait", {63'd0, busy}, 64'd1);
        run = 1'b0;
        do_reset();
        chk("rw_idle", 64'(busy), 64'd0);
        chk("rw_instret", instret, 64'd0);
        chk("rw_code", 64'(code), 64'd0);
        done = 4'b0001;
        step();
        done = 4'b0000;
        chk("rw_late_done_start", 64'(start), 64'd0);
        chk("rw_late_done_instret", instret, 64'd0);
        chk("rw_late_done_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
